// File: rtl/lpc_post_capture_pkg.sv
// Shared encodings for the LPC POST-code capture block.
// Build option LPC_POST_TIMESTAMP_EN widens each FIFO entry with a 16-bit timestamp.
package lpc_post_capture_pkg;

  localparam logic [15:0] LPC_POST_DEFAULT_ADDR = 16'h0080;

`ifdef LPC_POST_TIMESTAMP_EN
  localparam int LPC_POST_DATA_W = 24;
`else
  localparam int LPC_POST_DATA_W = 8;
`endif

  typedef enum logic [1:0] {
    LPC_POST_ST_IDLE    = 2'd0,
    LPC_POST_ST_CAPTURE = 2'd1,
    LPC_POST_ST_ACK     = 2'd2
  } lpc_post_st_e;

endpackage

// File: rtl/lpc_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a push into a full FIFO is accepted
// only when a pop retires the head in the same cycle.
module lpc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full_o     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty_o    = (r_wr_ptr == r_rd_ptr);
  assign w_pop_ok   = pop_i && !empty_o;
  assign w_push_ok  = push_i && (!full_o || w_pop_ok);
  assign level_o    = r_wr_ptr - r_rd_ptr;
  assign pop_data_o = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage carries no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/lpc_post_capture.sv
// POST-code capture behind the LPC peripheral: every I/O write is acknowledged, POST-port
// writes are queued, overflow is counted. Option: LPC_POST_TIMESTAMP_EN.
module lpc_post_capture
  import lpc_post_capture_pkg::*;
#(
  parameter logic [15:0] POST_ADDR = LPC_POST_DEFAULT_ADDR,
  parameter int          DEPTH     = 16,
  parameter int          TS_DIV    = 33
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [15:0]                lpc_addr_i,
  input  logic [7:0]                 lpc_data_i,
  input  logic                       lpc_data_wr_i,
  output logic                       lpc_wr_done_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [LPC_POST_DATA_W-1:0] out_data_o,
  output logic [$clog2(DEPTH):0]     fifo_level_o,
  output logic                       overflow_o,
  output logic [7:0]                 drop_cnt_o,
  input  logic                       clr_i
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("lpc_post_capture: DEPTH must be a power of two >= 2");
  end
  if (TS_DIV < 1) begin : g_bad_ts_div
    $error("lpc_post_capture: TS_DIV must be >= 1");
  end

  lpc_post_st_e               r_state;
  lpc_post_st_e               w_state_nxt;
  logic [15:0]                r_addr;
  logic [7:0]                 r_data;
  logic [7:0]                 r_drop_cnt;
  logic                       r_overflow;
  logic                       w_latch;
  logic                       w_capture;
  logic                       w_match;
  logic                       w_pop;
  logic                       w_drop;
  logic                       w_full;
  logic                       w_empty;
  logic [LPC_POST_DATA_W-1:0] w_entry;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= LPC_POST_ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_latch       = 1'b0;
    w_capture     = 1'b0;
    lpc_wr_done_o = 1'b0;
    case (r_state)
      LPC_POST_ST_IDLE: begin
        if (lpc_data_wr_i) begin
          w_latch     = 1'b1;
          w_state_nxt = LPC_POST_ST_CAPTURE;
        end
      end
      LPC_POST_ST_CAPTURE: begin
        w_capture   = 1'b1;
        w_state_nxt = LPC_POST_ST_ACK;
      end
      LPC_POST_ST_ACK: begin
        lpc_wr_done_o = 1'b1;
        if (!lpc_data_wr_i) w_state_nxt = LPC_POST_ST_IDLE;
      end
      default: w_state_nxt = LPC_POST_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr <= '0;
      r_data <= '0;
    end else if (w_latch) begin
      r_addr <= lpc_addr_i;
      r_data <= lpc_data_i;
    end
  end

  assign w_match     = w_capture && (r_addr == POST_ADDR);
  assign out_valid_o = !w_empty;
  assign w_pop       = !w_empty && out_ready_i;
  // A same-cycle pop frees the slot, so a full FIFO only drops when nothing leaves.
  assign w_drop      = w_match && w_full && !w_pop;

`ifdef LPC_POST_TIMESTAMP_EN
  localparam int DIV_W = $clog2(TS_DIV + 1);

  logic [DIV_W-1:0] r_ts_div;
  logic [15:0]      r_ts;
  logic [15:0]      r_ts_lat;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ts_div <= '0;
      r_ts     <= '0;
      r_ts_lat <= '0;
    end else begin
      if (r_ts_div == DIV_W'(TS_DIV - 1)) begin
        r_ts_div <= '0;
        r_ts     <= r_ts + 16'd1;
      end else begin
        r_ts_div <= r_ts_div + DIV_W'(1);
      end
      if (w_latch) r_ts_lat <= r_ts;
    end
  end

  assign w_entry = {r_ts_lat, r_data};
`else
  assign w_entry = r_data;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else if (clr_i) begin
      r_drop_cnt <= w_drop ? 8'd1 : 8'd0;
      r_overflow <= w_drop;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign overflow_o = r_overflow;
  assign drop_cnt_o = r_drop_cnt;

  lpc_sync_fifo #(
    .WIDTH (LPC_POST_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_match),
    .push_data_i (w_entry),
    .pop_i       (w_pop),
    .pop_data_o  (out_data_o),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .level_o     (fifo_level_o)
  );

endmodule

// File: tb/tb_lpc_post_capture.sv
// Self-checking bench for lpc_post_capture against a queue-based model of the POST FIFO.
`timescale 1ns/1ps
module tb_lpc_post_capture;
  import lpc_post_capture_pkg::*;

  localparam int DEPTH = 16;
  localparam int DW    = LPC_POST_DATA_W;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [15:0]   lpc_addr_i = '0;
  logic [7:0]    lpc_data_i = '0;
  logic          lpc_data_wr_i = 1'b0;
  logic          lpc_wr_done_o;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [DW-1:0] out_data_o;
  logic [4:0]    fifo_level_o;
  logic          overflow_o;
  logic [7:0]    drop_cnt_o;
  logic          clr_i = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq[$];
  int         m_drop = 0;
  bit         m_ovf  = 1'b0;

  lpc_post_capture #(.POST_ADDR(16'h0080), .DEPTH(DEPTH), .TS_DIV(4)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .lpc_addr_i    (lpc_addr_i),
    .lpc_data_i    (lpc_data_i),
    .lpc_data_wr_i (lpc_data_wr_i),
    .lpc_wr_done_o (lpc_wr_done_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_data_o    (out_data_o),
    .fifo_level_o  (fifo_level_o),
    .overflow_o    (overflow_o),
    .drop_cnt_o    (drop_cnt_o),
    .clr_i         (clr_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_write(input logic [15:0] a, input logic [7:0] d);
    if (a != 16'h0080) return;
    if (mq.size() < DEPTH) mq.push_back(d);
    else begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop++;
    end
  endfunction

  task automatic apply_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b1; lpc_data_wr_i = 1'b0; out_ready_i = 1'b0; clr_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    mq.delete(); m_drop = 0; m_ovf = 1'b0;
  endtask

  // lat = edges from driving the write until done is seen; -1 never acked, -2 done did not fall
  task automatic do_write(input logic [15:0] a, input logic [7:0] d, output int lat);
    lat = -1;
    @(posedge clk_i); #1;
    lpc_addr_i = a; lpc_data_i = d; lpc_data_wr_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk_i); #1;
      if (lpc_wr_done_o) begin lat = i; break; end
    end
    lpc_data_wr_i = 1'b0;
    @(posedge clk_i); #1;
    if (lat > 0 && lpc_wr_done_o) lat = -2;
  endtask

  task automatic do_pop(output bit v, output logic [DW-1:0] d);
    @(posedge clk_i); #1;
    v = out_valid_o; d = out_data_o; out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (lpc_wr_done_o !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", lpc_wr_done_o); end
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid_o); end
    total++; if (fifo_level_o !== 5'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", fifo_level_o); end
    total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow_o); end
    total++; if (drop_cnt_o !== 8'd0) begin bad++; $display("FAIL reset_drop: got %0d want 0", drop_cnt_o); end
  endtask

  task automatic test_first_write();
    int lat; bit v; logic [DW-1:0] d;
    do_write(16'h0080, 8'hA5, lat); model_write(16'h0080, 8'hA5);
    total++; if (lat != 2) begin bad++; $display("FAIL first_latency: got %0d want 2", lat); end
    total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL first_valid: got %b want 1", out_valid_o); end
    total++; if (out_data_o[7:0] !== 8'hA5) begin bad++; $display("FAIL first_data: got %h want a5", out_data_o[7:0]); end
    total++; if (fifo_level_o !== 5'd1) begin bad++; $display("FAIL first_level: got %0d want 1", fifo_level_o); end
  endtask

  task automatic test_nonmatch();
    int lat;
    do_write(16'h0084, 8'h11, lat); model_write(16'h0084, 8'h11);
    total++; if (lat != 2) begin bad++; $display("FAIL nonmatch_ack: got %0d want 2", lat); end
    total++; if (fifo_level_o !== mq.size()) begin bad++; $display("FAIL nonmatch_level: got %0d want %0d", fifo_level_o, mq.size()); end
    total++; if (drop_cnt_o !== 8'd0) begin bad++; $display("FAIL nonmatch_drop: got %0d want 0", drop_cnt_o); end
  endtask

  task automatic drain_check(input string name);
    bit v; logic [DW-1:0] d; logic [7:0] e;
    while (mq.size() > 0) begin
      do_pop(v, d); e = mq.pop_front();
      total++; if (!v || d[7:0] !== e) begin bad++; $display("FAIL %s: got v=%b d=%h want v=1 d=%h", name, v, d[7:0], e); end
    end
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL %s_empty: got valid=%b want 0", name, out_valid_o); end
  endtask

  task automatic test_overflow();
    int lat; int acks;
    apply_reset();
    acks = 0;
    for (int i = 0; i < 18; i++) begin
      do_write(16'h0080, 8'(i), lat); model_write(16'h0080, 8'(i));
      if (lat == 2) acks++;
    end
    total++; if (acks != 18) begin bad++; $display("FAIL ovf_acks: got %0d want 18", acks); end
    total++; if (fifo_level_o !== 5'd16) begin bad++; $display("FAIL ovf_level: got %0d want 16", fifo_level_o); end
    total++; if (drop_cnt_o !== 8'(m_drop)) begin bad++; $display("FAIL ovf_drop: got %0d want %0d", drop_cnt_o, m_drop); end
    total++; if (overflow_o !== m_ovf) begin bad++; $display("FAIL ovf_flag: got %b want %b", overflow_o, m_ovf); end
    drain_check("ovf_drain");
  endtask

  task automatic test_full_pop_and_clr();
    int lat; logic [7:0] head; logic [7:0] e;
    for (int i = 0; i < DEPTH; i++) begin
      do_write(16'h0080, 8'(8'h40 + i), lat); model_write(16'h0080, 8'(8'h40 + i));
    end
    // write with ready raised only for the CAPTURE edge
    @(posedge clk_i); #1; lpc_addr_i = 16'h0080; lpc_data_i = 8'h77; lpc_data_wr_i = 1'b1;
    @(posedge clk_i); #1; head = out_data_o[7:0]; out_ready_i = 1'b1;
    @(posedge clk_i); #1; out_ready_i = 1'b0; lpc_data_wr_i = 1'b0;
    @(posedge clk_i); #1;
    e = mq.pop_front(); mq.push_back(8'h77);
    total++; if (head !== e) begin bad++; $display("FAIL fullpop_head: got %h want %h", head, e); end
    total++; if (fifo_level_o !== 5'd16) begin bad++; $display("FAIL fullpop_level: got %0d want 16", fifo_level_o); end
    total++; if (drop_cnt_o !== 8'(m_drop)) begin bad++; $display("FAIL fullpop_drop: got %0d want %0d", drop_cnt_o, m_drop); end
    // drop coinciding with clear
    @(posedge clk_i); #1; lpc_addr_i = 16'h0080; lpc_data_i = 8'h99; lpc_data_wr_i = 1'b1;
    @(posedge clk_i); #1; clr_i = 1'b1;
    @(posedge clk_i); #1; clr_i = 1'b0; lpc_data_wr_i = 1'b0;
    @(posedge clk_i); #1;
    m_drop = 1; m_ovf = 1'b1;
    total++; if (drop_cnt_o !== 8'(m_drop)) begin bad++; $display("FAIL clr_drop_cnt: got %0d want %0d", drop_cnt_o, m_drop); end
    total++; if (overflow_o !== m_ovf) begin bad++; $display("FAIL clr_drop_ovf: got %b want %b", overflow_o, m_ovf); end
    @(posedge clk_i); #1; clr_i = 1'b1;
    @(posedge clk_i); #1; clr_i = 1'b0;
    m_drop = 0; m_ovf = 1'b0;
    total++; if (drop_cnt_o !== 8'd0) begin bad++; $display("FAIL clr_alone_cnt: got %0d want 0", drop_cnt_o); end
    total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL clr_alone_ovf: got %b want 0", overflow_o); end
    drain_check("fullpop_drain");
  endtask

  task automatic test_saturation();
    int lat;
    apply_reset();
    for (int i = 0; i < DEPTH + 260; i++) begin
      do_write(16'h0080, 8'(i), lat); model_write(16'h0080, 8'(i));
    end
    total++; if (drop_cnt_o !== 8'(m_drop)) begin bad++; $display("FAIL sat_cnt: got %0d want %0d", drop_cnt_o, m_drop); end
    total++; if (overflow_o !== m_ovf) begin bad++; $display("FAIL sat_ovf: got %b want %b", overflow_o, m_ovf); end
  endtask

  task automatic test_random();
    int lat; int npop; bit v; logic [DW-1:0] d; logic [7:0] e;
    logic [15:0] a; logic [7:0] dat;
    apply_reset();
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0:       a = 16'($urandom);
        1:       a = 16'h0081;
        default: a = 16'h0080;
      endcase
      dat = 8'($urandom);
      do_write(a, dat, lat); model_write(a, dat);
      total++; if (lat != 2) begin bad++; $display("FAIL rnd_ack: got %0d want 2", lat); end
      total++; if (fifo_level_o !== mq.size()) begin bad++; $display("FAIL rnd_level: got %0d want %0d", fifo_level_o, mq.size()); end
      total++; if (drop_cnt_o !== 8'(m_drop)) begin bad++; $display("FAIL rnd_drop: got %0d want %0d", drop_cnt_o, m_drop); end
      npop = (it % 3 == 0) ? 0 : $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) begin
        do_pop(v, d);
        if (mq.size() > 0) begin
          e = mq.pop_front();
          total++; if (!v || d[7:0] !== e) begin bad++; $display("FAIL rnd_pop: got v=%b d=%h want v=1 d=%h", v, d[7:0], e); end
        end else begin
          total++; if (v !== 1'b0) begin bad++; $display("FAIL rnd_empty: got valid=%b want 0", v); end
        end
      end
    end
    drain_check("rnd_drain");
  endtask

  task automatic test_reset_mid();
    int lat;
    apply_reset();
    @(posedge clk_i); #1; lpc_addr_i = 16'h0080; lpc_data_i = 8'h3C; lpc_data_wr_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    total++; if (lpc_wr_done_o !== 1'b1) begin bad++; $display("FAIL mid_in_ack: got %b want 1", lpc_wr_done_o); end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    mq.delete(); m_drop = 0; m_ovf = 1'b0;
    total++; if (lpc_wr_done_o !== 1'b0) begin bad++; $display("FAIL mid_done: got %b want 0", lpc_wr_done_o); end
    total++; if (fifo_level_o !== 5'd0) begin bad++; $display("FAIL mid_level: got %0d want 0", fifo_level_o); end
    rst_i = 1'b0;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk_i); #1;
      if (lpc_wr_done_o) begin lat = i; break; end
    end
    lpc_data_wr_i = 1'b0;
    @(posedge clk_i); #1;
    model_write(16'h0080, 8'h3C);
    total++; if (lat != 2) begin bad++; $display("FAIL mid_rewrite_ack: got %0d want 2", lat); end
    total++; if (fifo_level_o !== mq.size()) begin bad++; $display("FAIL mid_rewrite_level: got %0d want %0d", fifo_level_o, mq.size()); end
    drain_check("mid_drain");
  endtask

`ifdef LPC_POST_TIMESTAMP_EN
  task automatic test_timestamp();
    int lat; bit v1, v2; logic [DW-1:0] d1, d2; logic [15:0] diff;
    apply_reset();
    do_write(16'h0080, 8'h01, lat);
    repeat (36) @(posedge clk_i);
    do_write(16'h0080, 8'h02, lat);
    do_pop(v1, d1);
    do_pop(v2, d2);
    diff = d2[23:8] - d1[23:8];
    total++; if (!v1 || !v2 || diff !== 16'd10) begin bad++; $display("FAIL ts_diff: got v=%b%b diff=%0d want 11 10", v1, v2, diff); end
  endtask
`endif

  initial begin
    test_reset();
    test_first_write();
    test_nonmatch();
    test_overflow();
    test_full_pop_and_clr();
    test_saturation();
    test_random();
    test_reset_mid();
`ifdef LPC_POST_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lpc_post_capture.md
# lpc_post_capture

POST-code capture stage directly downstream of the LPC peripheral. It consumes that peripheral's I/O-write handshake and acknowledges every write so the host never stalls. Writes to the configured POST port are queued in a FIFO; the FIFO is drained by a valid/ready consumer such as a UART or debug-log streamer. Overflow is counted rather than back-pressured, because a stalled LPC long-wait would hang firmware.

## Interface
Parameters:
- POST_ADDR, 16'h0080: I/O address captured into the FIFO.
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- TS_DIV, 33: timestamp prescaler in clk_i cycles; only used with LPC_POST_TIMESTAMP_EN.

Ports:
- clk_i  in  1  LPC clock; all logic on posedge.
- rst_i  in  1  synchronous, active-high reset.
- lpc_addr_i  in  16  address from LPC peripheral.
- lpc_data_i  in  8  write data from LPC peripheral.
- lpc_data_wr_i  in  1  level: peripheral has write data pending.
- lpc_wr_done_o  out  1  write consumed; held until lpc_data_wr_i drops.
- out_valid_o  out  1  FIFO non-empty.
- out_ready_i  in  1  consumer accepts head entry.
- out_data_o  out  DATA_W  head entry; DATA_W = 8, or 24 with timestamp.
- fifo_level_o  out  $clog2(DEPTH)+1  current occupancy.
- overflow_o  out  1  sticky: at least one matching write dropped.
- drop_cnt_o  out  8  saturating count of dropped writes.
- clr_i  in  1  clears overflow_o and drop_cnt_o.

## Operation
- FSM states: IDLE, CAPTURE, ACK.
- IDLE:
  - lpc_data_wr_i=1 → latch lpc_addr_i and lpc_data_i, go to CAPTURE.
  - Otherwise stay in IDLE.
- CAPTURE:
  - If the latched address equals POST_ADDR: push when not full or when a pop occurs in the same cycle. Otherwise drop, set overflow_o, and increment drop_cnt_o (saturates at 255).
  - Non-matching address: no push, no count.
  - Always go to ACK.
- ACK:
  - lpc_wr_done_o=1.
  - When lpc_data_wr_i is sampled at 0, go to IDLE and deassert lpc_wr_done_o on the same edge.
- Every write is acknowledged, whether it matched, was pushed, or was dropped.
- Pop rule: out_valid_o & out_ready_i at a posedge removes the head entry. out_data_o is undefined while out_valid_o=0.
- Pointers are $clog2(DEPTH)+1 bits and wrap naturally.
  - full = MSBs differ and the low bits are equal.
  - empty = pointers equal.
- clr_i together with a drop in the same cycle: drop_cnt_o=1 and overflow_o=1, so the event is not lost.
- Reset, including mid-transaction: FSM to IDLE, FIFO emptied, counters and flags cleared. If lpc_data_wr_i is still high after reset, it is treated as a new write.

## Timing
- Reset values: lpc_wr_done_o=0, out_valid_o=0, fifo_level_o=0, overflow_o=0, drop_cnt_o=0, timestamp=0. out_data_o is don't-care.
- Let edge N be the first edge at which IDLE samples lpc_data_wr_i=1.
  - Edge N: data latched.
  - Edge N+1: pushed.
  - out_valid_o=1 after N+1 (2-cycle latency).
  - lpc_wr_done_o=1 after N+1.
- Minimum write-to-write spacing: 3 cycles.
- lpc_wr_done_o falls on the edge that samples lpc_data_wr_i=0.
- Pop plus push on a full FIFO in the same cycle: both happen, and the level stays at DEPTH.

## Configuration
- LPC_POST_TIMESTAMP_EN defined:
  - A 16-bit timestamp increments every TS_DIV clk_i cycles and wraps at 16'hFFFF.
  - Each entry is {timestamp[15:0], data[7:0]}; the timestamp is taken at edge N.
  - DATA_W=24.
- Undefined: no timestamp logic, entry is data only, DATA_W=8.

## Structure
- lpc_defines.v additions:
  - LPC_POST_ST_IDLE, LPC_POST_ST_CAPTURE, LPC_POST_ST_ACK state encodings.
  - LPC_POST_DEFAULT_ADDR.
- One sub-module: lpc_sync_fifo.
  - Parameters: WIDTH, DEPTH.
  - Ports: push/pop, full/empty, level.
  - Contains the pointer and full/empty logic.
- Top level holds the FSM, drop counter and timestamp.

## Test plan
- Reset, then a write to 0x0080 with data 0xA5 → lpc_wr_done_o high 2 cycles after lpc_data_wr_i rises; out_valid_o=1 with out_data_o[7:0]=0xA5; level=1.
- Write to 0x0084 data 0x11 → acknowledged; FIFO level unchanged; drop_cnt_o=0.
- 18 writes to 0x80 with out_ready_i=0, DEPTH=16 → level=16, drop_cnt_o=2, overflow_o=1; all writes acknowledged. Drain → 0x00..0x0F in order, with no duplicates across the wrap.
- FIFO full, write with out_ready_i=1 in the CAPTURE cycle → entry accepted, drop_cnt_o unchanged, level=16.
- Pulse clr_i in the same cycle as a drop → drop_cnt_o=1, overflow_o=1. Pulse clr_i alone → both 0.
- rst_i asserted while in ACK with lpc_data_wr_i high → next cycle lpc_wr_done_o=0, level=0. With LPC_POST_TIMESTAMP_EN and TS_DIV=4: two writes 40 cycles apart → timestamp difference 10.
